// File: rtl/gpio_cfg_serial_loader_if.sv
// Bus between the housekeeping config source and the GPIO serial chain loader.
// The master side requests a load and supplies config words; the slave side drives the chain.
interface gpio_cfg_serial_loader_if #(
    parameter int unsigned NUM_PADS = 38,
    parameter int unsigned CFG_BITS = 13
);
    localparam int unsigned IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                xfer_start;
    logic [IDX_W-1:0]    cfg_idx;
    logic [CFG_BITS-1:0] cfg_word;
    logic                busy;
    logic                done;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;
    logic                serial_resetn;

    modport master (
        output xfer_start,
        output cfg_word,
        input  cfg_idx,
        input  busy,
        input  done,
        input  serial_clock,
        input  serial_data,
        input  serial_load,
        input  serial_resetn
    );

    modport slave (
        input  xfer_start,
        input  cfg_word,
        output cfg_idx,
        output busy,
        output done,
        output serial_clock,
        output serial_data,
        output serial_load,
        output serial_resetn
    );
endinterface

// File: rtl/gpio_cfg_serial_loader.sv
// Serialises one config word per pad (pad NUM_PADS-1 first, MSB first) into the GPIO
// control-block chain, then strobes serial_load so all pads latch together.
module gpio_cfg_serial_loader #(
    parameter int unsigned NUM_PADS = 38,
    parameter int unsigned CFG_BITS = 13,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    gpio_cfg_serial_loader_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int unsigned PH_W  = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(CFG_BITS + 1);

    localparam logic [IDX_W-1:0] LAST_PAD = IDX_W'(NUM_PADS - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [CFG_BITS-1:0] shreg;
    logic [CFG_BITS-1:0] shreg_shl;
    logic [PH_W-1:0]     ph_cnt;
    logic [BIT_W-1:0]    bit_cnt;

    assign shreg_shl = shreg << 1;

    // Single registered FSM: outputs change on the same edge as the state they belong to.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state             <= IDLE;
            shreg             <= '0;
            ph_cnt            <= '0;
            bit_cnt           <= '0;
            bus.cfg_idx       <= LAST_PAD;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.serial_clock  <= 1'b0;
            bus.serial_data   <= 1'b0;
            bus.serial_load   <= 1'b0;
            bus.serial_resetn <= 1'b0;
        end else begin
            bus.serial_resetn <= 1'b1;
            bus.done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.xfer_start) begin
                        bus.busy <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    shreg            <= bus.cfg_word;
                    bit_cnt          <= '0;
                    ph_cnt           <= '0;
                    bus.serial_clock <= 1'b0;
                    bus.serial_data  <= bus.cfg_word[CFG_BITS-1];
                    state            <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (ph_cnt == PH_LAST) begin
                        ph_cnt           <= '0;
                        bus.serial_clock <= 1'b1;
                        state            <= SHIFT_HI;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (ph_cnt == PH_LAST) begin
                        ph_cnt           <= '0;
                        bus.serial_clock <= 1'b0;
                        // bit_cnt holds bits already completed before this one
                        if (bit_cnt < BIT_LAST) begin
                            bit_cnt         <= bit_cnt + BIT_W'(1);
                            shreg           <= shreg_shl;
                            bus.serial_data <= shreg_shl[CFG_BITS-1];
                            state           <= SHIFT_LO;
                        end else if (bus.cfg_idx != '0) begin
                            bus.cfg_idx <= bus.cfg_idx - IDX_W'(1);
                            state       <= FETCH;
                        end else begin
                            bus.serial_load <= 1'b1;
                            bus.serial_data <= 1'b0;
                            state           <= LOAD;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                LOAD: begin
                    if (ph_cnt == PH_LAST) begin
                        ph_cnt          <= '0;
                        bus.serial_load <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        bus.cfg_idx     <= LAST_PAD;
                        state           <= DONE;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Directed bench for gpio_cfg_serial_loader: small, default and slow-clock instances,
// each with a shift-register model of the pad chain latched on serial_load.
module tb_gpio_cfg_serial_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A: 2 pads x 3 bits, CLK_DIV=1.  B: defaults.  C: 3 pads x 4 bits, CLK_DIV=3.
    gpio_cfg_serial_loader_if #(.NUM_PADS(2),  .CFG_BITS(3))  if_a ();
    gpio_cfg_serial_loader_if #(.NUM_PADS(38), .CFG_BITS(13)) if_b ();
    gpio_cfg_serial_loader_if #(.NUM_PADS(3),  .CFG_BITS(4))  if_c ();

    gpio_cfg_serial_loader #(.NUM_PADS(2),  .CFG_BITS(3),  .CLK_DIV(1))
        dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .bus(if_a.slave));
    gpio_cfg_serial_loader #(.NUM_PADS(38), .CFG_BITS(13), .CLK_DIV(4))
        dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .bus(if_b.slave));
    gpio_cfg_serial_loader #(.NUM_PADS(3),  .CFG_BITS(4),  .CLK_DIV(3))
        dut_c (.wb_clk_i(clk), .wb_rst_i(rst), .bus(if_c.slave));

    logic [2:0]  words_a [2];
    logic [12:0] words_b [38];
    logic [3:0]  words_c [3];

    assign if_a.cfg_word = words_a[if_a.cfg_idx];
    assign if_b.cfg_word = words_b[if_b.cfg_idx];
    assign if_c.cfg_word = words_c[if_c.cfg_idx];

    // Chain models: first bit shifted ends at the MSB, last bit at the chain head (LSB).
    logic [5:0]   chain_a = '0, latch_a = '0;
    logic [493:0] chain_b = '0, latch_b = '0;
    logic [11:0]  chain_c = '0, latch_c = '0;
    int rises_a = 0, rises_b = 0, rises_c = 0;
    int load_a = 0, load_b = 0, load_c = 0;
    int done_a = 0, done_b = 0, done_c = 0;

    always @(posedge if_a.serial_clock) begin chain_a = {chain_a[4:0], if_a.serial_data}; rises_a++; end
    always @(posedge if_b.serial_clock) begin chain_b = {chain_b[492:0], if_b.serial_data}; rises_b++; end
    always @(posedge if_c.serial_clock) begin chain_c = {chain_c[10:0], if_c.serial_data}; rises_c++; end
    always @(posedge if_a.serial_load) latch_a = chain_a;
    always @(posedge if_b.serial_load) latch_b = chain_b;
    always @(posedge if_c.serial_load) latch_c = chain_c;

    always @(negedge clk) begin
        if (if_a.serial_load) load_a++;
        if (if_b.serial_load) load_b++;
        if (if_c.serial_load) load_c++;
        if (if_a.done) done_a++;
        if (if_b.done) done_b++;
        if (if_c.done) done_c++;
    end

    // Phase-length and data-hold monitor for the CLK_DIV=3 instance.
    logic mon_c = 1'b0, prev_sc = 1'b0, sd_hold = 1'b0;
    int   hi_len = 0, lo_len = 0, rise_c = 0, sd_bad = 0;
    always @(negedge clk) begin
        if (mon_c) begin
            if (if_c.serial_clock && !prev_sc) begin
                if (rise_c > 0) chk("c_lo_len", 64'(lo_len), 64'((rise_c % 4 == 0) ? 4 : 3));
                rise_c++;
                hi_len  = 1;
                sd_hold = if_c.serial_data;
            end else if (if_c.serial_clock) begin
                hi_len++;
                if (if_c.serial_data !== sd_hold) sd_bad++;
            end else if (prev_sc) begin
                chk("c_hi_len", 64'(hi_len), 64'd3);
                chk("c_data_hold", 64'(sd_bad), 64'd0);
                sd_bad = 0;
                lo_len = 1;
            end else begin
                lo_len++;
            end
            prev_sc = if_c.serial_clock;
        end
    end

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return if_a.done;
            1:       return if_b.done;
            default: return if_c.done;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       if_a.xfer_start = v;
            1:       if_b.xfer_start = v;
            default: if_c.xfer_start = v;
        endcase
    endtask

    task automatic clear_counts();
        rises_a = 0; rises_b = 0; rises_c = 0;
        load_a  = 0; load_b  = 0; load_c  = 0;
        done_a  = 0; done_b  = 0; done_c  = 0;
    endtask

    // Latency = rising edges counted from the accepting edge (=1) to the edge raising done.
    // With poke set, xfer_start is re-pulsed while in SHIFT_HI (cycle 3) and LOAD (cycle 15).
    task automatic start_and_wait(input int sel, input bit poke, input int limit, output int lat);
        int n;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        n = 1;
        #1;
        set_start(sel, 1'b0);
        while (!get_done(sel) && n < limit) begin
            @(posedge clk);
            n++;
            #1;
            if (poke) set_start(sel, (n == 3) || (n == 15));
        end
        lat = get_done(sel) ? n : 0;
        if (!get_done(sel)) $display("FAIL timeout sel=%0d: no done after %0d cycles", sel, n);
    endtask

    typedef struct {
        logic [2:0] w1;
        logic [2:0] w0;
        logic [5:0] bits;
        bit         poke;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int n;
        logic [12:0] prev_b [38];

        vecs[0] = '{w1: 3'b101, w0: 3'b011, bits: 6'b101011, poke: 1'b0};
        vecs[1] = '{w1: 3'b000, w0: 3'b111, bits: 6'b000111, poke: 1'b0};
        vecs[2] = '{w1: 3'b110, w0: 3'b001, bits: 6'b110001, poke: 1'b0};
        vecs[3] = '{w1: 3'b111, w0: 3'b111, bits: 6'b111111, poke: 1'b0};
        vecs[4] = '{w1: 3'b010, w0: 3'b100, bits: 6'b010100, poke: 1'b1};

        if_a.xfer_start = 1'b0;
        if_b.xfer_start = 1'b0;
        if_c.xfer_start = 1'b0;
        for (int p = 0; p < 2; p++)  words_a[p] = '0;
        for (int p = 0; p < 38; p++) words_b[p] = 13'($urandom);
        for (int p = 0; p < 3; p++)  words_c[p] = 4'($urandom);

        // Reset values while held, then serial_resetn only after the first edge past release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      64'(if_a.busy),          64'd0);
        chk("rst_done",      64'(if_a.done),          64'd0);
        chk("rst_sclk",      64'(if_a.serial_clock),  64'd0);
        chk("rst_sdata",     64'(if_a.serial_data),   64'd0);
        chk("rst_sload",     64'(if_a.serial_load),   64'd0);
        chk("rst_sresetn",   64'(if_a.serial_resetn), 64'd0);
        chk("rst_idx_a",     64'(if_a.cfg_idx),       64'd1);
        chk("rst_idx_b",     64'(if_b.cfg_idx),       64'd37);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("resetn_pre_edge", 64'(if_b.serial_resetn), 64'd0);
        @(posedge clk);
        #1;
        chk("resetn_post_edge", 64'(if_b.serial_resetn), 64'd1);

        // Table-driven transfers on the 2-pad instance.
        for (int i = 0; i < 5; i++) begin
            words_a[1] = vecs[i].w1;
            words_a[0] = vecs[i].w0;
            clear_counts();
            start_and_wait(0, vecs[i].poke, 100, lat);
            repeat (20) @(posedge clk);
            #1;
            chk($sformatf("a%0d_latency", i), 64'(lat),     64'd16);
            chk($sformatf("a%0d_bits", i),    64'(latch_a), 64'(vecs[i].bits));
            chk($sformatf("a%0d_rises", i),   64'(rises_a), 64'd6);
            chk($sformatf("a%0d_load", i),    64'(load_a),  64'd1);
            chk($sformatf("a%0d_dones", i),   64'(done_a),  64'd1);
            chk($sformatf("a%0d_busy", i),    64'(if_a.busy),    64'd0);
            chk($sformatf("a%0d_idx", i),     64'(if_a.cfg_idx), 64'd1);
        end

        // Full default chain.
        clear_counts();
        start_and_wait(1, 1'b0, 5000, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("b_latency", 64'(lat),     64'd3995);
        chk("b_rises",   64'(rises_b), 64'd494);
        chk("b_load",    64'(load_b),  64'd4);
        chk("b_dones",   64'(done_b),  64'd1);
        for (int p = 0; p < 38; p++)
            chk($sformatf("b_pad%0d", p), 64'(latch_b[p*13 +: 13]), 64'(words_b[p]));

        // Abort mid-shift at pad 20 bit 5; latched chain must be untouched.
        for (int p = 0; p < 38; p++) begin
            prev_b[p]  = words_b[p];
            words_b[p] = 13'($urandom);
        end
        clear_counts();
        @(negedge clk);
        if_b.xfer_start = 1'b1;
        @(negedge clk);
        if_b.xfer_start = 1'b0;
        n = 0;
        while (!(if_b.cfg_idx == 6'd20 && rises_b == 17*13 + 5) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_pad20_bit5", 64'(n < 5000), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_busy",    64'(if_b.busy),          64'd0);
        chk("t5_async_sclk",    64'(if_b.serial_clock),  64'd0);
        chk("t5_async_sresetn", 64'(if_b.serial_resetn), 64'd0);
        chk("t5_async_idx",     64'(if_b.cfg_idx),       64'd37);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_load", 64'(load_b), 64'd0);
        chk("t5_no_done", 64'(done_b), 64'd0);
        for (int p = 0; p < 38; p += 9)
            chk($sformatf("t5_kept_pad%0d", p), 64'(latch_b[p*13 +: 13]), 64'(prev_b[p]));

        clear_counts();
        start_and_wait(1, 1'b0, 5000, lat);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_restart_latency", 64'(lat),     64'd3995);
        chk("t5_restart_rises",   64'(rises_b), 64'd494);
        chk("t5_restart_load",    64'(load_b),  64'd4);
        for (int p = 0; p < 38; p++)
            chk($sformatf("t5_pad%0d", p), 64'(latch_b[p*13 +: 13]), 64'(words_b[p]));

        // Slow serial clock: 3 pads x 4 bits, CLK_DIV=3 -> 3*(1+24)+3+1 = 79 cycles.
        clear_counts();
        prev_sc = 1'b0;
        rise_c  = 0;
        sd_bad  = 0;
        lo_len  = 0;
        mon_c   = 1'b1;
        start_and_wait(2, 1'b0, 500, lat);
        repeat (10) @(posedge clk);
        #1;
        mon_c = 1'b0;
        chk("c_latency", 64'(lat),     64'd79);
        chk("c_rises",   64'(rises_c), 64'd12);
        chk("c_load",    64'(load_c),  64'd3);
        chk("c_dones",   64'(done_c),  64'd1);
        for (int p = 0; p < 3; p++)
            chk($sformatf("c_pad%0d", p), 64'(latch_c[p*4 +: 4]), 64'(words_c[p]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
